// File: rtl/acc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : acc_pkg
// Purpose  : Shared definitions for the accumulator bank: command encoding,
//            control FSM states and default sizing constants.
// Revision : 1.0 - initial release
// ============================================================================
package acc_pkg;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_NUM_ACC = 4;
  localparam int DEF_SHAMT_W = 4;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_LOAD  = 2'b01,
    OP_CLEAR = 2'b10,
    OP_SHIFT = 2'b11
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/acc_shift1.sv
`default_nettype none
// ============================================================================
// Module   : acc_shift1
// Purpose  : Combinational single-bit shifter used by the SHIFT state.
//            dir=0: logical left (LSB filled with 0)
//            dir=1: arithmetic right (MSB replicated)
// Ports    : din     - value to shift
//            dir     - shift direction
//            dout    - shifted value
//            out_bit - bit that falls off the end
// Revision : 1.0 - initial release
// ============================================================================
module acc_shift1 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] din,
  input  logic             dir,
  output logic [WIDTH-1:0] dout,
  output logic             out_bit
);

  always_comb begin
    if (dir) begin
      dout    = {din[WIDTH-1], din[WIDTH-1:1]};
      out_bit = din[0];
    end else begin
      dout    = {din[WIDTH-2:0], 1'b0};
      out_bit = din[WIDTH-1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/acc_bank.sv
`default_nettype none
// ============================================================================
// Module   : acc_bank
// Purpose  : Bank of NUM_ACC accumulators with LOAD / CLEAR / multi-cycle
//            SHIFT commands, a registered read port and result flags.
// Ports    : clk, rst (async, active-high)
//            start, op, wr_sel, dir, shamt, from_alu - command interface
//            rd_sel                                  - read-port select
//            to_alu, to_mbr                          - registered acc[rd_sel]
//            busy, done                              - status
//            flag_n, flag_z                          - sign / zero of result
//            flag_c  (only with ACC_BANK_CARRY_EN)   - last bit shifted out
// Config   : define ACC_BANK_CARRY_EN to add the flag_c output.
// Revision : 1.0 - initial release
// ============================================================================
module acc_bank
  import acc_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_ACC = DEF_NUM_ACC,
  parameter int SHAMT_W = DEF_SHAMT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [1:0]                 op,
  input  logic [$clog2(NUM_ACC)-1:0] wr_sel,
  input  logic                       dir,
  input  logic [SHAMT_W-1:0]         shamt,
  input  logic [WIDTH-1:0]           from_alu,
  input  logic [$clog2(NUM_ACC)-1:0] rd_sel,
  output logic [WIDTH-1:0]           to_alu,
  output logic [WIDTH-1:0]           to_mbr,
  output logic                       busy,
  output logic                       done,
  output logic                       flag_n,
  output logic                       flag_z
`ifdef ACC_BANK_CARRY_EN
  ,
  output logic                       flag_c
`endif
);

  localparam int SEL_W = $clog2(NUM_ACC);

  logic [WIDTH-1:0] acc [NUM_ACC];
  state_e           state, state_nx;
  logic [SHAMT_W-1:0] cnt;
  logic [SEL_W-1:0] tgt;
  logic             dir_q;
  logic             accept;
  logic             last_step;
  logic [WIDTH-1:0] sh_val;
  logic             sh_out;

  // Shifter always works on the latched target so rd_sel/wr_sel may change
  // freely while a shift is in progress.
  acc_shift1 #(.WIDTH(WIDTH)) u_shift1 (
    .din     (acc[tgt]),
    .dir     (dir_q),
    .dout    (sh_val),
    .out_bit (sh_out)
  );

`ifndef ACC_BANK_CARRY_EN
  logic sh_out_unused;
  assign sh_out_unused = sh_out;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    last_step = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept = 1'b1;
          // shamt=0 completes in one cycle without ever becoming busy
          if (op_e'(op) == OP_SHIFT && shamt != '0) state_nx = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt == SHAMT_W'(1)) begin
          last_step = 1'b1;
          state_nx  = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_SHIFT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ACC; i++) acc[i] <= '0;
      to_alu <= '0;
      to_mbr <= '0;
      done   <= 1'b0;
      flag_n <= 1'b0;
      flag_z <= 1'b0;
      cnt    <= '0;
      tgt    <= '0;
      dir_q  <= 1'b0;
`ifdef ACC_BANK_CARRY_EN
      flag_c <= 1'b0;
`endif
    end else begin
      to_alu <= acc[rd_sel];
      to_mbr <= acc[rd_sel];
      done   <= 1'b0;

      if (accept) begin
        case (op_e'(op))
          OP_NOP: done <= 1'b1;
          OP_LOAD: begin
            acc[wr_sel] <= from_alu;
            done        <= 1'b1;
            flag_n      <= from_alu[WIDTH-1];
            flag_z      <= (from_alu == '0);
`ifdef ACC_BANK_CARRY_EN
            flag_c      <= 1'b0;
`endif
          end
          OP_CLEAR: begin
            acc[wr_sel] <= '0;
            done        <= 1'b1;
            flag_n      <= 1'b0;
            flag_z      <= 1'b1;
`ifdef ACC_BANK_CARRY_EN
            flag_c      <= 1'b0;
`endif
          end
          OP_SHIFT: begin
            tgt   <= wr_sel;
            dir_q <= dir;
            cnt   <= shamt;
            if (shamt == '0) begin
              done   <= 1'b1;
              flag_n <= acc[wr_sel][WIDTH-1];
              flag_z <= (acc[wr_sel] == '0);
`ifdef ACC_BANK_CARRY_EN
              flag_c <= 1'b0;
`endif
            end
          end
          default: ;
        endcase
      end

      if (busy) begin
        acc[tgt] <= sh_val;
        cnt      <= cnt - SHAMT_W'(1);
        if (last_step) begin
          done   <= 1'b1;
          flag_n <= sh_val[WIDTH-1];
          flag_z <= (sh_val == '0);
`ifdef ACC_BANK_CARRY_EN
          flag_c <= sh_out;
`endif
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_acc_bank.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_acc_bank
// Purpose  : Self-checking bench for acc_bank: directed vector table,
//            hand-written reset/back-to-back sequences, random commands
//            against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_acc_bank;
  import acc_pkg::*;

  localparam int W    = 16;
  localparam int N    = 4;
  localparam int SW   = 4;
  localparam int SELW = $clog2(N);

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [1:0]      op;
  logic [SELW-1:0] wr_sel, rd_sel;
  logic            dir;
  logic [SW-1:0]   shamt;
  logic [W-1:0]    from_alu, to_alu, to_mbr;
  logic            busy, done, flag_n, flag_z;
`ifdef ACC_BANK_CARRY_EN
  logic            flag_c;
`endif

  acc_bank #(.WIDTH(W), .NUM_ACC(N), .SHAMT_W(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .wr_sel(wr_sel),
    .dir(dir), .shamt(shamt), .from_alu(from_alu), .rd_sel(rd_sel),
    .to_alu(to_alu), .to_mbr(to_mbr), .busy(busy), .done(done),
    .flag_n(flag_n), .flag_z(flag_z)
`ifdef ACC_BANK_CARRY_EN
    , .flag_c(flag_c)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [W-1:0] m_acc [N];
  logic         m_n, m_z, m_c;

  typedef struct {
    logic [1:0]      op;
    logic [SELW-1:0] sel;
    logic            dir;
    logic [SW-1:0]   k;
    logic [W-1:0]    data;
    logic [W-1:0]    exp;
    logic            en;
    logic            ez;
  } vec_t;

  vec_t tbl [7];

  task automatic chkv(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] shf(input logic [W-1:0] v, input logic d, input int k);
    logic signed [W-1:0] s;
    s = v;
    if (d) return s >>> k;
    return v << k;
  endfunction

  function automatic logic cout(input logic [W-1:0] v, input logic d, input int k);
    if (k == 0) return 1'b0;
    if (d) return (k <= W) ? v[k-1] : v[W-1];
    return (k <= W) ? v[W-k] : 1'b0;
  endfunction

  task automatic model_reset;
    for (int i = 0; i < N; i++) m_acc[i] = '0;
    m_n = 1'b0; m_z = 1'b0; m_c = 1'b0;
  endtask

  // Issues a command in the current cycle (edge T is the next edge) and
  // returns positioned in the done cycle, so a following call is back-to-back.
  task automatic do_cmd(input logic [1:0] o, input logic [SELW-1:0] s, input logic d,
                        input logic [SW-1:0] k, input logic [W-1:0] data, input bit noise);
    logic [W-1:0] v, r;
    int kk;
    v  = m_acc[s];
    kk = int'(k);
    start = 1'b1; op = o; wr_sel = s; dir = d; shamt = k; from_alu = data; rd_sel = s;
    tick;
    start = 1'b0;
    if (o == OP_SHIFT && kk > 0) begin
      for (int i = 1; i <= kk; i++) begin
        chk1("busy_during_shift", busy, 1'b1);
        chk1("done_during_shift", done, 1'b0);
        chkv("intermediate_read", to_alu, shf(v, d, (i >= 2) ? i - 2 : 0));
        if (noise) begin
          start = 1'b1; op = 2'($urandom); wr_sel = SELW'($urandom);
          from_alu = W'($urandom); shamt = SW'($urandom); dir = 1'($urandom);
        end
        tick;
        start = 1'b0;
      end
      chkv("read_at_done", to_alu, shf(v, d, kk - 1));
    end else begin
      chkv("read_latency", to_alu, v);
    end
    case (o)
      OP_LOAD:  begin m_acc[s] = data; m_n = data[W-1]; m_z = (data == '0); m_c = 1'b0; end
      OP_CLEAR: begin m_acc[s] = '0;   m_n = 1'b0;      m_z = 1'b1;         m_c = 1'b0; end
      OP_SHIFT: begin
        r = shf(v, d, kk);
        m_acc[s] = r; m_n = r[W-1]; m_z = (r == '0); m_c = cout(v, d, kk);
      end
      default: ;
    endcase
    chk1("done_pulse", done, 1'b1);
    chk1("busy_at_done", busy, 1'b0);
    chk1("flag_n", flag_n, m_n);
    chk1("flag_z", flag_z, m_z);
`ifdef ACC_BANK_CARRY_EN
    chk1("flag_c", flag_c, m_c);
`endif
  endtask

  task automatic rdchk(input logic [SELW-1:0] s);
    rd_sel = s;
    tick;
    chkv("to_alu", to_alu, m_acc[s]);
    chkv("to_mbr", to_mbr, m_acc[s]);
    chk1("done_after_pulse", done, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{OP_LOAD,  2'd2, 1'b0, 4'd0,  16'h8001, 16'h8001, 1'b1, 1'b0};
    tbl[1] = '{OP_SHIFT, 2'd2, 1'b1, 4'd3,  16'h0000, 16'hF000, 1'b1, 1'b0};
    tbl[2] = '{OP_LOAD,  2'd1, 1'b0, 4'd0,  16'h0003, 16'h0003, 1'b0, 1'b0};
    tbl[3] = '{OP_SHIFT, 2'd1, 1'b0, 4'd15, 16'h0000, 16'h8000, 1'b1, 1'b0};
    tbl[4] = '{OP_CLEAR, 2'd0, 1'b0, 4'd0,  16'h1234, 16'h0000, 1'b0, 1'b1};
    tbl[5] = '{OP_SHIFT, 2'd0, 1'b1, 4'd0,  16'h0000, 16'h0000, 1'b0, 1'b1};
    tbl[6] = '{OP_NOP,   2'd0, 1'b0, 4'd7,  16'hFFFF, 16'h0000, 1'b0, 1'b1};

    rst = 1'b1; start = 1'b0; op = '0; wr_sel = '0; rd_sel = '0; dir = 1'b0;
    shamt = '0; from_alu = '0;
    model_reset();
    tick; tick;
    chkv("reset_to_alu", to_alu, '0);
    chkv("reset_to_mbr", to_mbr, '0);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_done", done, 1'b0);
    chk1("reset_flag_n", flag_n, 1'b0);
    chk1("reset_flag_z", flag_z, 1'b0);
    rst = 1'b0;
    tick;

    // directed vector table
    for (int i = 0; i < 7; i++) begin
      do_cmd(tbl[i].op, tbl[i].sel, tbl[i].dir, tbl[i].k, tbl[i].data, i == 3);
      chk1("tbl_flag_n", flag_n, tbl[i].en);
      chk1("tbl_flag_z", flag_z, tbl[i].ez);
      rd_sel = tbl[i].sel;
      tick;
      chkv("tbl_value", to_alu, tbl[i].exp);
    end

    // back-to-back: LOAD issued in the done cycle of a SHIFT
    do_cmd(OP_LOAD, 2'd3, 1'b0, 4'd0, 16'h00F0, 1'b0);
    do_cmd(OP_SHIFT, 2'd3, 1'b0, 4'd2, 16'h0000, 1'b0);
    do_cmd(OP_LOAD, 2'd0, 1'b0, 4'd0, 16'h7FFF, 1'b0);
    rdchk(2'd3);
    rdchk(2'd0);

    // reset in cycle T+2 of a shamt=5 shift
    do_cmd(OP_LOAD, 2'd3, 1'b0, 4'd0, 16'hC0DE, 1'b0);
    start = 1'b1; op = OP_SHIFT; wr_sel = 2'd3; dir = 1'b1; shamt = 4'd5; rd_sel = 2'd3;
    tick;
    start = 1'b0;
    tick;
    rst = 1'b1;
    #1;
    chkv("midrst_to_alu", to_alu, '0);
    chkv("midrst_to_mbr", to_mbr, '0);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_done", done, 1'b0);
    chk1("midrst_flag_n", flag_n, 1'b0);
    chk1("midrst_flag_z", flag_z, 1'b0);
    model_reset();
    tick;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      chk1("no_done_after_abort", done, 1'b0);
      chk1("no_busy_after_abort", busy, 1'b0);
    end
    rdchk(2'd3);
    do_cmd(OP_LOAD, 2'd3, 1'b0, 4'd0, 16'h0101, 1'b0);
    rdchk(2'd3);

    // randomized commands against the model
    for (int n = 0; n < 80; n++) begin
      logic [1:0]      ro;
      logic [SELW-1:0] rs;
      ro = 2'($urandom_range(0, 3));
      rs = SELW'($urandom);
      do_cmd(ro, rs, 1'($urandom), SW'($urandom), W'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) == 0) rdchk(SELW'($urandom));
    end
    for (int i = 0; i < N; i++) rdchk(SELW'(i));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
